// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: push-button inputs plus counter/latch controls between stopwatch_ctrl and its datapath
interface stopwatch_ctrl_if;
    logic [1:0] KEY;
    logic       CNT_EN;
    logic       CNT_CLR;
    logic       LAP_LOAD;
    logic       LAP_HOLD;
    logic [1:0] STATE;
    modport master (input KEY, output CNT_EN, CNT_CLR, LAP_LOAD, LAP_HOLD, STATE);
    modport slave (output KEY, input CNT_EN, CNT_CLR, LAP_LOAD, LAP_HOLD, STATE);
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: key debounce, start/stop/lap/clear FSM and centisecond prescaler
module stopwatch_ctrl #(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int TICK_DIV   = 500_000
) (
    input logic              CLOCK_50,
    input logic              RESET,
    stopwatch_ctrl_if.master sw
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LAP = 2'b11;
    logic [1:0]    sync1, sync2, deb, press;
    logic [DW-1:0] deb_cnt [2];
    logic [TW-1:0] presc;
    logic [1:0]    state, state_nxt;
    logic          ev0, ev1, running, clr_nxt, load_nxt;
    assign sw.STATE = state;
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sync1   <= '1;
            sync2   <= '1;
            deb     <= '1;
            press   <= '0;
            deb_cnt <= '{'0, '0};
        end else begin
            sync1 <= sw.KEY;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == deb[i]) deb_cnt[i] <= '0;
                else if (deb_cnt[i] == DW'(DEB_CYCLES)) begin
                    deb_cnt[i] <= '0;
                    deb[i]     <= sync2[i];
                    press[i]   <= ~sync2[i];
                end else deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
        end
    end
    // RUN and LAP are the only states with bit 0 set; start/stop wins over lap/clear
    always_comb begin
        running   = state[0];
        ev0       = press[0];
        ev1       = press[1] & ~press[0];
        state_nxt = ev0 ? (running ? PAUSE : RUN) :
                    ev1 ? (running ? (state == RUN ? LAP : RUN) : IDLE) : state;
        clr_nxt   = ev1 & ~running;
        load_nxt  = ev1 & (state == RUN);
    end
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state       <= IDLE;
            presc       <= '0;
            sw.CNT_EN   <= 1'b0;
            sw.CNT_CLR  <= 1'b0;
            sw.LAP_LOAD <= 1'b0;
            sw.LAP_HOLD <= 1'b0;
        end else begin
            state       <= state_nxt;
            sw.CNT_EN   <= running && presc == TW'(TICK_DIV - 1);
            sw.CNT_CLR  <= clr_nxt;
            sw.LAP_LOAD <= load_nxt;
            sw.LAP_HOLD <= state_nxt == LAP;
            presc       <= clr_nxt ? '0 : !running ? presc :
                           presc == TW'(TICK_DIV - 1) ? '0 : presc + 1'b1;
        end
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: scenario tasks checked against a window/table reference model of the stopwatch
module tb_stopwatch_ctrl;
    localparam int DEB = 4, TICK = 5;
    logic clk = 1'b0, rst = 1'b1;
    stopwatch_ctrl_if sw ();
    stopwatch_ctrl #(.DEB_CYCLES(DEB), .TICK_DIV(TICK)) dut (.CLOCK_50(clk), .RESET(rst), .sw(sw));
    always #5 clk = ~clk;
    int checks = 0, failures = 0;
    int on_k0 [4] = '{1, 2, 1, 2};
    int on_k1 [4] = '{0, 3, 0, 1};
    int m_state = 0, m_run = 0;
    logic m_en = 0, m_clr = 0, m_load = 0, m_hold = 0;
    logic [1:0] m_deb = '1, m_press = '0;
    logic [DEB+2:0] m_hist [2];
    logic [5:0] got, exp_v;
    assign got   = {sw.STATE, sw.CNT_EN, sw.CNT_CLR, sw.LAP_LOAD, sw.LAP_HOLD};
    assign exp_v = {m_state[1:0], m_en, m_clr, m_load, m_hold};
    // A key's level flips once its last DEB+1 raw samples (ignoring the newest) all disagree with it
    task automatic model(input logic [1:0] k, input logic r);
        logic e0, e1, run_now, fl;
        int ns;
        if (r) begin
            m_state = 0; m_run = 0; m_en = 0; m_clr = 0; m_load = 0; m_hold = 0;
            m_deb = '1; m_press = '0; m_hist[0] = '1; m_hist[1] = '1;
            return;
        end
        e0 = m_press[0];
        e1 = m_press[1] && !e0;
        ns = e0 ? on_k0[m_state] : e1 ? on_k1[m_state] : m_state;
        run_now = m_state == 1 || m_state == 3;
        m_clr  = e1 && (m_state == 0 || m_state == 2);
        m_load = e1 && m_state == 1;
        m_en   = run_now && m_run % TICK == TICK - 1;
        m_run  = m_clr ? 0 : run_now ? m_run + 1 : m_run;
        m_state = ns;
        m_hold = ns == 3;
        for (int i = 0; i < 2; i++) begin
            fl = m_hist[i][DEB+1:1] == {(DEB+1){~m_deb[i]}};
            m_press[i] = fl && m_deb[i];
            if (fl) m_deb[i] = ~m_deb[i];
            m_hist[i] = {m_hist[i][DEB+1:0], k[i]};
        end
    endtask
    task automatic step(input logic [1:0] k, input logic r);
        sw.KEY = k;
        rst = r;
        @(posedge clk);
        model(k, r);
        @(negedge clk);
    endtask
    task automatic test_reset;
        for (int i = 0; i < 3; i++) step(2'b11, 1'b1);
        checks++;
        if (got !== 6'b0) begin failures++; $display("FAIL reset_outputs got=%b exp=%b", got, 6'b0); end
        for (int i = 0; i < 20; i++) begin
            step(2'b11, 1'b0);
            checks++;
            if (got !== 6'b0) begin failures++; $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i, got, 6'b0); end
        end
    endtask
    task automatic test_start;
        int first_en = -1, n_en = 0, last = -1;
        for (int i = 0; i < 58; i++) begin
            step(i < 10 ? 2'b10 : 2'b11, 1'b0);
            checks++;
            if (got !== exp_v) begin failures++; $display("FAIL start_model edge=%0d got=%b exp=%b", i, got, exp_v); end
            if (i == 6 || i == 7) begin
                checks++;
                if (sw.STATE !== (i == 7 ? 2'b01 : 2'b00)) begin failures++; $display("FAIL start_state edge=%0d got=%b", i, sw.STATE); end
            end
            if (i >= 8 && sw.CNT_EN === 1'b1) begin
                n_en++;
                if (first_en < 0) first_en = i;
                else begin
                    checks++;
                    if (i - last != TICK) begin failures++; $display("FAIL start_period edge=%0d got=%0d exp=%0d", i, i - last, TICK); end
                end
                last = i;
            end
        end
        checks++;
        if (first_en != 12) begin failures++; $display("FAIL start_first_en got=%0d exp=12", first_en); end
        checks++;
        if (n_en != 10) begin failures++; $display("FAIL start_en_count got=%0d exp=10", n_en); end
    endtask
    task automatic test_bounce;
        int lo, hi;
        step(2'b11, 1'b1);
        step(2'b11, 1'b1);
        for (int r = 0; r < 6; r++) begin
            lo = $urandom_range(1, DEB - 1);
            hi = $urandom_range(1, 2);
            for (int i = 0; i < lo + hi; i++) begin
                step(i < lo ? 2'b10 : 2'b11, 1'b0);
                checks++;
                if (got !== exp_v || sw.STATE !== 2'b00) begin failures++; $display("FAIL bounce_reject got=%b exp=%b", got, exp_v); end
            end
        end
        for (int i = 0; i < 22; i++) begin
            step(i < 12 ? 2'b10 : 2'b11, 1'b0);
            checks++;
            if (got !== exp_v) begin failures++; $display("FAIL bounce_model edge=%0d got=%b exp=%b", i, got, exp_v); end
            if (i == 6 || i == 7) begin
                checks++;
                if (sw.STATE !== (i == 7 ? 2'b01 : 2'b00)) begin failures++; $display("FAIL bounce_accept edge=%0d got=%b", i, sw.STATE); end
            end
        end
    endtask
    task automatic test_lap;
        int n_load = 0, last = -1;
        for (int i = 0; i < 40; i++) begin
            step((i < 8 || (i >= 20 && i < 28)) ? 2'b01 : 2'b11, 1'b0);
            checks++;
            if (got !== exp_v) begin failures++; $display("FAIL lap_model edge=%0d got=%b exp=%b", i, got, exp_v); end
            if (sw.LAP_LOAD === 1'b1) n_load++;
            if (i == 7) begin
                checks++;
                if ({sw.STATE, sw.LAP_LOAD, sw.LAP_HOLD} !== 4'b1111) begin failures++; $display("FAIL lap_enter got=%b exp=1111", {sw.STATE, sw.LAP_LOAD, sw.LAP_HOLD}); end
            end
            if (i == 27) begin
                checks++;
                if ({sw.STATE, sw.LAP_LOAD, sw.LAP_HOLD} !== 4'b0100) begin failures++; $display("FAIL lap_leave got=%b exp=0100", {sw.STATE, sw.LAP_LOAD, sw.LAP_HOLD}); end
            end
            if (sw.CNT_EN === 1'b1) begin
                if (last >= 0) begin
                    checks++;
                    if (i - last != TICK) begin failures++; $display("FAIL lap_cadence edge=%0d got=%0d exp=%0d", i, i - last, TICK); end
                end
                last = i;
            end
        end
        checks++;
        if (n_load != 1) begin failures++; $display("FAIL lap_load_count got=%0d exp=1", n_load); end
    endtask
    task automatic test_pause_clear;
        int n_clr = 0;
        logic k0, k1;
        for (int g = 0; g < TICK && (m_run + DEB + 3) % TICK != 2; g++) step(2'b11, 1'b0);
        for (int t = 0; t < 80; t++) begin
            k0 = t < 8 || (t >= 20 && t < 28) || (t >= 40 && t < 48);
            k1 = t >= 60 && t < 68;
            step({~k1, ~k0}, 1'b0);
            checks++;
            if (got !== exp_v) begin failures++; $display("FAIL pause_model edge=%0d got=%b exp=%b", t, got, exp_v); end
            if (sw.CNT_CLR === 1'b1) n_clr++;
            if (t == 7 || t == 47) begin
                checks++;
                if (sw.STATE !== 2'b10) begin failures++; $display("FAIL pause_state edge=%0d got=%b exp=10", t, sw.STATE); end
            end
            if (t >= 8 && t < 29) begin
                checks++;
                if (sw.CNT_EN !== 1'b0) begin failures++; $display("FAIL pause_en_stopped edge=%0d got=%b exp=0", t, sw.CNT_EN); end
            end
            if (t == 29) begin
                checks++;
                if ({sw.STATE, sw.CNT_EN} !== 3'b011) begin failures++; $display("FAIL resume_first_en got=%b exp=011", {sw.STATE, sw.CNT_EN}); end
            end
            if (t == 67) begin
                checks++;
                if ({sw.STATE, sw.CNT_CLR} !== 3'b001) begin failures++; $display("FAIL clear_pulse got=%b exp=001", {sw.STATE, sw.CNT_CLR}); end
            end
        end
        checks++;
        if (n_clr != 1) begin failures++; $display("FAIL clear_count got=%0d exp=1", n_clr); end
    endtask
    task automatic test_simul_reset;
        int n_load = 0;
        logic k0, k1;
        for (int t = 0; t < 72; t++) begin
            k0 = t < 8 || (t >= 20 && t < 28) || (t >= 40 && t < 48);
            k1 = (t >= 20 && t < 28) || (t >= 60 && t < 68);
            step({~k1, ~k0}, t == 70);
            checks++;
            if (got !== exp_v) begin failures++; $display("FAIL simul_model edge=%0d got=%b exp=%b", t, got, exp_v); end
            if (t >= 20 && t < 40 && sw.LAP_LOAD === 1'b1) n_load++;
            if (t == 11 || t == 12) begin
                checks++;
                if (sw.CNT_EN !== (t == 12)) begin failures++; $display("FAIL clear_presc edge=%0d got=%b", t, sw.CNT_EN); end
            end
            if (t == 27) begin
                checks++;
                if (sw.STATE !== 2'b10) begin failures++; $display("FAIL simul_k0_wins got=%b exp=10", sw.STATE); end
            end
            if (t == 67) begin
                checks++;
                if ({sw.STATE, sw.LAP_HOLD} !== 3'b111) begin failures++; $display("FAIL simul_lap got=%b exp=111", {sw.STATE, sw.LAP_HOLD}); end
            end
            if (t >= 70) begin
                checks++;
                if (got !== 6'b0) begin failures++; $display("FAIL lap_reset edge=%0d got=%b exp=%b", t, got, 6'b0); end
            end
        end
        checks++;
        if (n_load != 0) begin failures++; $display("FAIL simul_no_load got=%0d exp=0", n_load); end
    endtask
    task automatic test_held_reset;
        for (int i = 0; i < 3; i++) step(2'b10, 1'b1);
        for (int t = 0; t < 20; t++) begin
            step(t < 10 ? 2'b10 : 2'b11, 1'b0);
            checks++;
            if (got !== exp_v) begin failures++; $display("FAIL held_model edge=%0d got=%b exp=%b", t, got, exp_v); end
            if (t == 6 || t == 7) begin
                checks++;
                if (sw.STATE !== (t == 7 ? 2'b01 : 2'b00)) begin failures++; $display("FAIL held_press edge=%0d got=%b", t, sw.STATE); end
            end
        end
    endtask
    task automatic test_random;
        logic [1:0] k = 2'b11;
        int dur [2] = '{1, 1};
        logic r;
        step(2'b11, 1'b1);
        for (int t = 0; t < 800; t++) begin
            for (int i = 0; i < 2; i++) begin
                dur[i]--;
                if (dur[i] == 0) begin
                    k[i] = ~k[i];
                    dur[i] = $urandom_range(1, 10);
                end
            end
            r = $urandom_range(0, 299) == 0;
            step(k, r);
            checks++;
            if (got !== exp_v) begin failures++; $display("FAIL random_model cyc=%0d got=%b exp=%b", t, got, exp_v); end
            checks++;
            if (sw.CNT_CLR === 1'b1 && sw.LAP_LOAD === 1'b1) begin failures++; $display("FAIL random_exclusive cyc=%0d got=11 exp=not both", t); end
        end
    endtask
    initial begin
        sw.KEY = 2'b11;
        @(negedge clk);
        test_reset();
        test_start();
        test_bounce();
        test_lap();
        test_pause_clear();
        test_simul_reset();
        test_held_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
